l1_dcache: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage (EX/MEM ALU result and store data) and the external 256-bit data memory. It answers hits in the same cycle. On a miss it raises `p1_stall_o`, which freezes the pipeline registers. It then writes back a dirty victim line if there is one, refills the line from memory, and releases the stall.

---
 rtl/l1_dcache.sv | 104 ++++++++++
 tb/tb_l1_dcache.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-back write-allocate L1 data cache with miss stall
module l1_dcache #(
  parameter int depth = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int IW = $clog2(depth);
  localparam int TW = 27 - IW;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t state_q, state_d;
  logic [depth-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TW-1:0] tag_q [depth];
  logic [255:0] data_q [depth];
  logic [IW-1:0] idx;
  logic [TW-1:0] req_tag;
  logic [7:0] bit_base;
  logic req, store, hit, fill, wr_hit;
  logic unused_addr_bits;
  assign idx = p1_addr_i[4+IW:5];
  assign req_tag = p1_addr_i[31:5+IW];
  assign bit_base = {p1_addr_i[4:2], 5'b0};
  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign store = p1_MemWrite_i;
  assign hit = req & valid_q[idx] & (tag_q[idx] == req_tag);
  assign unused_addr_bits = ^p1_addr_i[1:0];
  // next state, line bookkeeping and all outputs from the live request
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    fill = 1'b0;
    wr_hit = 1'b0;
    p1_data_o = 32'b0;
    mem_enable_o = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o = 32'b0;
    mem_data_o = 256'b0;
    p1_stall_o = (state_q != IDLE) | (req & !hit);
    unique case (state_q)
      IDLE: begin
        if (hit && store) begin
          wr_hit = 1'b1;
          dirty_d[idx] = 1'b1;
        end else if (hit) begin
          p1_data_o = data_q[idx][bit_base +: 32];
        end else if (req) begin
          state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o = {tag_q[idx], idx, 5'b0};
        mem_data_o = data_q[idx];
        state_d = mem_ack_i ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o = {req_tag, idx, 5'b0};
        if (mem_ack_i) begin
          fill = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and per-line valid/dirty flags, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end
  // tag and data arrays need no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem_data_i;
      tag_q[idx] <= req_tag;
    end else if (wr_hit) begin
      data_q[idx][bit_base +: 32] <= p1_data_i;
    end
  end
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed scoreboard bench for l1_dcache
module tb_l1_dcache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] p1_addr_i = '0, p1_data_i = '0;
  logic p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
  logic [31:0] p1_data_o, mem_addr_o;
  logic p1_stall_o, mem_enable_o, mem_write_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic mem_ack_i = 1'b0;
  logic [255:0] exp_q [$];
  int passed = 0, total = 0;
  logic [255:0] l0, l1, l2, l3, l4, l5, l6, wb;

  l1_dcache #(.depth(32)) dut (
    .clk(clk), .rst(rst),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + i;
    return l;
  endfunction

  task automatic expect_v(input logic [255:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string nm, input logic [255:0] obs);
    logic [255:0] e;
    e = exp_q.pop_front();
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", nm, obs, e);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    p1_MemRead_i = rd; p1_MemWrite_i = wr; p1_addr_i = a; p1_data_i = d;
  endtask

  task automatic miss_txn(input string nm, input logic wr, input logic [31:0] a,
                          input logic [255:0] wb_line, input logic [255:0] fill_line, input int n);
    int t;
    t = 0;
    expect_v(256'(1)); expect_v(256'(wr)); expect_v(256'(a));
    if (wr) expect_v(wb_line);
    @(negedge clk);
    while (!mem_enable_o && t < 20) begin @(negedge clk); t++; end
    check({nm, "_en"}, 256'(mem_enable_o));
    check({nm, "_wr"}, 256'(mem_write_o));
    check({nm, "_addr"}, 256'(mem_addr_o));
    if (wr) check({nm, "_wbdata"}, mem_data_o);
    repeat (n) begin
      @(posedge clk); #1;
      expect_v(256'(a)); expect_v(256'(1));
      @(negedge clk);
      check({nm, "_addr_hold"}, 256'(mem_addr_o));
      check({nm, "_stall_hold"}, 256'(p1_stall_o));
    end
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_data_i = fill_line;
    @(posedge clk); #1;
    mem_ack_i = 1'b0; mem_data_i = '0;
  endtask

  task automatic after_fill(input string nm, input logic [31:0] d);
    expect_v(256'(0)); expect_v(256'(d)); expect_v(256'(0));
    @(negedge clk);
    check({nm, "_stall"}, 256'(p1_stall_o));
    check({nm, "_data"}, 256'(p1_data_o));
    check({nm, "_en"}, 256'(mem_enable_o));
  endtask

  task automatic stall_now(input string nm, input logic s);
    expect_v(256'(s));
    @(negedge clk);
    check({nm, "_stall"}, 256'(p1_stall_o));
  endtask

  initial begin
    l0 = mk_line(32'h1000_0000); l0[63:32] = 32'hDEADBEEF;
    l1 = mk_line(32'h2000_0000);
    l2 = mk_line(32'h3000_0000);
    l3 = mk_line(32'h4000_0000);
    l4 = mk_line(32'h5000_0000);
    l5 = mk_line(32'h6000_0000);
    l6 = mk_line(32'h7000_0000);
    expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(0);
    @(negedge clk);
    check("rst_stall", 256'(p1_stall_o));
    check("rst_en", 256'(mem_enable_o));
    check("rst_wr", 256'(mem_write_o));
    check("rst_addr", 256'(mem_addr_o));
    check("rst_wdata", mem_data_o);
    check("rst_pdata", 256'(p1_data_o));
    @(posedge clk); #1 rst = 1'b1;
    drive(1, 0, 32'h0000_0044, 0);
    stall_now("cold", 1);
    miss_txn("cold", 0, 32'h0000_0040, '0, l0, 2);
    after_fill("cold", 32'hDEADBEEF);
    drive(0, 1, 32'h0000_0048, 32'h1234_5678);
    stall_now("st_hit", 0);
    drive(1, 0, 32'h0000_0048, 0);
    after_fill("ld_st", 32'h1234_5678);
    drive(1, 0, 32'h0000_0044, 0);
    after_fill("ld_w1", 32'hDEADBEEF);
    wb = l0; wb[95:64] = 32'h1234_5678;
    drive(1, 0, 32'h0000_0440, 0);
    stall_now("dirty", 1);
    miss_txn("dirty_wb", 1, 32'h0000_0040, wb, '0, 1);
    miss_txn("dirty_rf", 0, 32'h0000_0440, '0, l1, 0);
    after_fill("dirty", 32'h2000_0000);
    drive(1, 0, 32'h0000_0840, 0);
    stall_now("clean", 1);
    miss_txn("clean", 0, 32'h0000_0840, '0, l2, 0);
    after_fill("clean", 32'h3000_0000);
    drive(0, 1, 32'h0000_1000, 32'hA5A5_A5A5);
    stall_now("st_miss", 1);
    miss_txn("st_miss", 0, 32'h0000_1000, '0, l3, 1);
    stall_now("st_merge", 0);
    wb = l3; wb[31:0] = 32'hA5A5_A5A5;
    drive(1, 0, 32'h0000_2000, 0);
    miss_txn("st_evict_wb", 1, 32'h0000_1000, wb, '0, 0);
    miss_txn("st_evict_rf", 0, 32'h0000_2000, '0, l4, 0);
    after_fill("st_evict", 32'h5000_0000);
    drive(1, 0, 32'hFFFF_FFFC, 0);
    miss_txn("wrap", 0, 32'hFFFF_FFE0, '0, l6, 0);
    after_fill("wrap", 32'h7000_0007);
    drive(1, 0, 32'h0000_3044, 0);
    expect_v(256'(1));
    @(negedge clk); @(negedge clk);
    check("mid_en_before", 256'(mem_enable_o));
    #1 rst = 1'b0;
    expect_v(0); expect_v(0); expect_v(256'(1));
    #1;
    check("mid_rst_en", 256'(mem_enable_o));
    check("mid_rst_addr", 256'(mem_addr_o));
    check("mid_rst_stall", 256'(p1_stall_o));
    @(posedge clk); #1 rst = 1'b1;
    stall_now("mid_again", 1);
    miss_txn("mid_again", 0, 32'h0000_3040, '0, l5, 0);
    after_fill("mid_again", 32'h6000_0001);
    drive(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
